load_replay_sched: RTL and testbench
====================================

Name: load_replay_sched

Overview:
- Buffers loads that the load pipeline rejected at s1 (bank conflict, cache miss, mmio, store-forward not ready).
- Holds each rejected load until its blocking condition clears, then re-injects it into load-pipe s0.
- Arbitrates load-pipe s0 between this replay buffer and the issue queue.
- Sits between the load issue queue, the load FU s0 mux and the s1 feedback path.

Parameters:
DEPTH, 8, number of replay entries
LQ_W, 5, load-queue index width
CFT_DLY, 2, cycles a bank-conflict entry waits before becoming ready (1..15)
STARVE_LIM, 8, consecutive IQ-denied cycles before IQ is forced through (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_squash  in  1  pipeline flush; drops every entry
i_iq_vld  in  1  issue queue has a load for s0 this cycle
o_iq_gnt  out  1  IQ load accepted into s0 this cycle
i_rp_vld  in  1  s1 replay feedback valid
i_rp_lqIdx  in  LQ_W  lqIdx of replayed load
i_rp_cause  in  2  0=conflict 1=miss 2=mmio 3=stfwd_notrdy
i_refill_wake  in  1  dcache refill completed
i_mmio_wake  in  1  mmio path ready
i_stfwd_wake  in  1  store data became ready in storeque/sbuffer
o_rp_vld  out  1  replay entry injected into s0 this cycle
o_rp_lqIdx  out  LQ_W  lqIdx of injected replay
o_free_cnt  out  $clog2(DEPTH+1)  free entry count

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: all entries FREE, rr pointer 0, counters 0, o_free_cnt=DEPTH.
- Reset: o_iq_gnt, o_rp_vld and o_rp_lqIdx are 0 whenever rst or i_squash is high.
- Per-entry states and transitions:
  - FREE -> WAIT on push.
  - WAIT -> READY when the wake matching its cause is seen.
  - READY -> FREE when selected for s0.
- Wake per cause:
  - conflict: per-entry down-counter loaded with CFT_DLY; READY when it reaches 0.
  - miss: i_refill_wake, broadcast to all miss entries.
  - mmio: i_mmio_wake.
  - stfwd_notrdy: i_stfwd_wake.
- Push allocates the lowest-index FREE entry.
- Push and matching wake in the same cycle: the entry goes directly to READY (no lost wakeup).
- Push with no free entry is an illegal condition; assert on it.
- Replay selection: round-robin over READY entries, starting at rr pointer.
- rr pointer moves to selected index+1, wrapping modulo DEPTH.
- Injected entry is freed in that same cycle. A pushed entry is not selectable until the next cycle.
- s0 arbitration: replay has priority.
  - o_rp_vld = any READY.
  - o_iq_gnt = i_iq_vld && !o_rp_vld && (o_free_cnt > 2).
- The free-count guard reserves room for loads in flight in s0/s1, each of which may replay.
- o_free_cnt is registered; it reflects pushes and pops of the previous cycle.
- Simultaneous push and pop in one cycle: count unchanged.
- Squash: all entries FREE next cycle and o_free_cnt=DEPTH. Push, wake and selection in the squash cycle are ignored.
- No stall input: s0 never back-pressures, so selection equals acceptance.

Optional Feature:
LDRP_STARVE_EN
- With it: a counter increments each cycle i_iq_vld && !o_iq_gnt && free_cnt>2, and clears on grant or when i_iq_vld=0.
  - When it reaches STARVE_LIM, IQ wins that cycle: o_rp_vld=0, o_iq_gnt=1, counter clears.
  - The rr pointer does not advance that cycle.
- Without it: strict replay priority, no counter logic.

Decomposition:
- Shared package holds:
  - ldrp_cause_t enum (CONFLICT, MISS, MMIO, STFWD).
  - ldrp_state_t enum (FREE, WAIT, READY).
  - The entry struct {state, cause, lqIdx, dly_cnt}.
- One sub-module is natural: ldrp_entry, a single-entry FSM with its delay counter.
  - Inputs: alloc, cause, wakes, select, squash.
  - Outputs: ready, free.
- The top level holds allocation, round-robin selection, the free counter and s0 arbitration.

Test Plan:
- Conflict replay: push lqIdx=3, cause=0, CFT_DLY=2 -> o_rp_vld=1 with o_rp_lqIdx=3 exactly 3 cycles after the push; IQ denied that cycle.
- Miss wake broadcast: push lqIdx 1,2,4 as misses, then i_refill_wake -> lqIdx 1,2,4 injected in round-robin order on 3 consecutive cycles.
- Same-cycle push+wake: push cause=3 while i_stfwd_wake=1 -> injected next cycle, no hang.
- Capacity guard: fill 6 of 8 entries, hold i_iq_vld=1, no wakes -> o_iq_gnt=0 and o_free_cnt=2; push with 0 free triggers the assertion.
- Squash: 5 entries pending, i_squash=1 -> next cycle o_free_cnt=8 and o_rp_vld=0; a push in the squash cycle is dropped.
- LDRP_STARVE_EN, STARVE_LIM=8: continuous READY replays with i_iq_vld=1 -> o_iq_gnt=1 on the 9th cycle, then replays resume.

Source files
------------

// File: rtl/load_replay_sched_pkg.sv
// Shared types for the load replay scheduler.
// Holds the replay cause and per-entry state enums, the entry record, and the
// wake-match helper used by every entry.
package load_replay_sched_pkg;

  // Width of the stored lqIdx; the top-level LQ_W must match this value.
  localparam int unsigned LdrpLqW  = 5;
  // Conflict delay counter width, enough for a delay of 1..15.
  localparam int unsigned LdrpDlyW = 4;

  typedef enum logic [1:0] {
    CauseConflict = 2'd0,
    CauseMiss     = 2'd1,
    CauseMmio     = 2'd2,
    CauseStfwd    = 2'd3
  } ldrp_cause_t;

  typedef enum logic [1:0] {
    StFree  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2
  } ldrp_state_t;

  typedef struct packed {
    ldrp_state_t          state;
    ldrp_cause_t          cause;
    logic [LdrpLqW-1:0]   lq_idx;
    logic [LdrpDlyW-1:0]  dly_cnt;
  } ldrp_entry_t;

  // True when the broadcast wake matching this cause is active. Conflict
  // entries wake on their own delay counter, never on a broadcast.
  function automatic logic ldrp_wake_hit(ldrp_cause_t cause, logic refill, logic mmio,
                                         logic stfwd);
    logic hit;
    hit = 1'b0;
    unique case (cause)
      CauseConflict: hit = 1'b0;
      CauseMiss:     hit = refill;
      CauseMmio:     hit = mmio;
      CauseStfwd:    hit = stfwd;
      default:       hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/load_replay_sched_entry.sv
// Single replay-buffer entry (ldrp entry): FREE -> WAIT -> READY -> FREE.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   squash_i              drop the entry (back to FREE next cycle)
//   alloc_i               capture cause_i / lq_idx_i this cycle
//   cause_i, lq_idx_i     replay cause and load-queue index
//   refill_wake_i, mmio_wake_i, stfwd_wake_i   broadcast wakes
//   select_i              entry chosen for s0 this cycle
//   ready_o, free_o       current state flags
//   lq_idx_o              stored lqIdx
module load_replay_sched_entry
  import load_replay_sched_pkg::*;
#(
  parameter int unsigned CftDly = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               squash_i,
  input  logic               alloc_i,
  input  logic [1:0]         cause_i,
  input  logic [LdrpLqW-1:0] lq_idx_i,
  input  logic               refill_wake_i,
  input  logic               mmio_wake_i,
  input  logic               stfwd_wake_i,
  input  logic               select_i,
  output logic               ready_o,
  output logic               free_o,
  output logic [LdrpLqW-1:0] lq_idx_o
);

  ldrp_entry_t ent_q, ent_d;
  ldrp_cause_t cause_in;

  assign cause_in = ldrp_cause_t'(cause_i);

  always_comb begin
    ent_d = ent_q;
    unique case (ent_q.state)
      StFree: begin
        if (alloc_i) begin
          ent_d.cause   = cause_in;
          ent_d.lq_idx  = lq_idx_i;
          ent_d.dly_cnt = LdrpDlyW'(CftDly);
          // A wake arriving with the push must not be lost.
          ent_d.state   = ldrp_wake_hit(cause_in, refill_wake_i, mmio_wake_i, stfwd_wake_i)
                          ? StReady : StWait;
        end
      end
      StWait: begin
        if (ent_q.cause == CauseConflict) begin
          // Becomes READY on the cycle the counter would hit zero.
          if (ent_q.dly_cnt <= LdrpDlyW'(1)) begin
            ent_d.state   = StReady;
            ent_d.dly_cnt = '0;
          end else begin
            ent_d.dly_cnt = ent_q.dly_cnt - LdrpDlyW'(1);
          end
        end else if (ldrp_wake_hit(ent_q.cause, refill_wake_i, mmio_wake_i, stfwd_wake_i)) begin
          ent_d.state = StReady;
        end
      end
      StReady: begin
        if (select_i) begin
          ent_d.state = StFree;
        end
      end
      default: ent_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || squash_i) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign ready_o  = (ent_q.state == StReady);
  assign free_o   = (ent_q.state == StFree);
  assign lq_idx_o = ent_q.lq_idx;

endmodule

// File: rtl/load_replay_sched.sv
// Load replay scheduler: buffers loads rejected at s1, re-injects them into
// load-pipe s0 once their blocking condition clears, and arbitrates s0
// between replays and the issue queue (replay wins).
// Optional feature macro: LDRP_STARVE_EN -- after STARVE_LIM consecutive
// IQ-denied cycles, the IQ is forced through for one cycle.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_squash                    flush: every entry dropped
//   i_iq_vld / o_iq_gnt         issue-queue request / grant into s0
//   i_rp_vld, i_rp_lqIdx, i_rp_cause   s1 replay push
//   i_refill_wake, i_mmio_wake, i_stfwd_wake   broadcast wakes
//   o_rp_vld, o_rp_lqIdx        replay injected into s0
//   o_free_cnt                  registered free-entry count
module load_replay_sched
  import load_replay_sched_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LQ_W       = LdrpLqW,
  parameter int unsigned CFT_DLY    = 2,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_squash,
  input  logic                       i_iq_vld,
  output logic                       o_iq_gnt,
  input  logic                       i_rp_vld,
  input  logic [LQ_W-1:0]            i_rp_lqIdx,
  input  logic [1:0]                 i_rp_cause,
  input  logic                       i_refill_wake,
  input  logic                       i_mmio_wake,
  input  logic                       i_stfwd_wake,
  output logic                       o_rp_vld,
  output logic [LQ_W-1:0]            o_rp_lqIdx,
  output logic [$clog2(DEPTH+1)-1:0] o_free_cnt
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] free_vec, ready_vec, alloc_vec, select_vec;
  logic [LQ_W-1:0]  lq_arr [DEPTH];

  logic [IdxW-1:0]  rr_q, rr_d;
  logic [CntW-1:0]  free_cnt_q, free_cnt_d;

  logic             has_free, push, any_ready, free_ok, rp_fire, iq_gnt, starve_force;
  logic [IdxW-1:0]  alloc_idx, sel_idx;
  logic             sel_found;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    load_replay_sched_entry #(
      .CftDly(CFT_DLY)
    ) u_ent (
      .clk          (clk),
      .rst          (rst),
      .squash_i     (i_squash),
      .alloc_i      (alloc_vec[g]),
      .cause_i      (i_rp_cause),
      .lq_idx_i     (i_rp_lqIdx),
      .refill_wake_i(i_refill_wake),
      .mmio_wake_i  (i_mmio_wake),
      .stfwd_wake_i (i_stfwd_wake),
      .select_i     (select_vec[g]),
      .ready_o      (ready_vec[g]),
      .free_o       (free_vec[g]),
      .lq_idx_o     (lq_arr[g])
    );
  end

  assign has_free  = |free_vec;
  assign any_ready = |ready_vec;
  assign push      = i_rp_vld && has_free && !i_squash && !rst;
  assign free_ok   = (free_cnt_q > CntW'(2));

  // Lowest-index free entry.
  always_comb begin
    alloc_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (free_vec[k]) alloc_idx = IdxW'(k);
    end
  end

  // Round-robin pick among READY entries, starting at rr_q.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      cand = (32'(rr_q) + 32'(k)) % DEPTH;
      if (!sel_found && ready_vec[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(cand);
      end
    end
  end

  assign rp_fire = any_ready && !starve_force && !rst && !i_squash;
  assign iq_gnt  = !rst && !i_squash && i_iq_vld && free_ok && (starve_force || !any_ready);

  always_comb begin
    alloc_vec  = '0;
    select_vec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      alloc_vec[k]  = push && (alloc_idx == IdxW'(k));
      select_vec[k] = rp_fire && (sel_idx == IdxW'(k));
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (rp_fire) begin
      rr_d = (32'(sel_idx) == DEPTH - 1) ? '0 : sel_idx + IdxW'(1);
    end
  end

  always_comb begin
    free_cnt_d = free_cnt_q;
    if (i_squash) begin
      free_cnt_d = CntW'(DEPTH);
    end else begin
      case ({push, rp_fire})
        2'b10:   free_cnt_d = free_cnt_q - CntW'(1);
        2'b01:   free_cnt_d = free_cnt_q + CntW'(1);
        default: free_cnt_d = free_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      free_cnt_q <= CntW'(DEPTH);
    end else begin
      rr_q       <= rr_d;
      free_cnt_q <= free_cnt_d;
    end
  end

`ifdef LDRP_STARVE_EN
  localparam int unsigned StW = $clog2(STARVE_LIM + 1);
  logic [StW-1:0] starve_q, starve_d;

  assign starve_force = i_iq_vld && free_ok && (starve_q >= StW'(STARVE_LIM));

  always_comb begin
    starve_d = starve_q;
    if (!i_iq_vld || iq_gnt) begin
      starve_d = '0;
    end else if (free_ok) begin
      starve_d = starve_q + StW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_squash) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  assign o_iq_gnt   = iq_gnt;
  assign o_rp_vld   = rp_fire;
  assign o_rp_lqIdx = rp_fire ? lq_arr[sel_idx] : '0;
  assign o_free_cnt = free_cnt_q;

`ifndef SYNTHESIS
  // The free-count guard on IQ grants must keep the buffer from overflowing.
  always_ff @(posedge clk) begin
    if (!rst && !i_squash && i_rp_vld) begin
      assert (has_free) else $error("load_replay_sched: push with no free entry");
    end
  end
`endif

endmodule

// File: tb/tb_load_replay_sched.sv
module tb_load_replay_sched;

`ifdef LDRP_STARVE_EN
  localparam bit Starve = 1'b1;
`else
  localparam bit Starve = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, i_squash, i_iq_vld, i_rp_vld;
  logic [4:0] i_rp_lqIdx;
  logic [1:0] i_rp_cause;
  logic       i_refill_wake, i_mmio_wake, i_stfwd_wake;
  logic       o_iq_gnt, o_rp_vld;
  logic [4:0] o_rp_lqIdx;
  logic [3:0] o_free_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_replay_sched dut (
    .clk          (clk),
    .rst          (rst),
    .i_squash     (i_squash),
    .i_iq_vld     (i_iq_vld),
    .o_iq_gnt     (o_iq_gnt),
    .i_rp_vld     (i_rp_vld),
    .i_rp_lqIdx   (i_rp_lqIdx),
    .i_rp_cause   (i_rp_cause),
    .i_refill_wake(i_refill_wake),
    .i_mmio_wake  (i_mmio_wake),
    .i_stfwd_wake (i_stfwd_wake),
    .o_rp_vld     (o_rp_vld),
    .o_rp_lqIdx   (o_rp_lqIdx),
    .o_free_cnt   (o_free_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clear all per-cycle strobes (iq_vld left as is).
  task automatic quiet();
    i_squash      = 1'b0;
    i_rp_vld      = 1'b0;
    i_rp_lqIdx    = '0;
    i_rp_cause    = '0;
    i_refill_wake = 1'b0;
    i_mmio_wake   = 1'b0;
    i_stfwd_wake  = 1'b0;
  endtask

  task automatic push(input logic [4:0] lq, input logic [1:0] cause);
    i_rp_vld   = 1'b1;
    i_rp_lqIdx = lq;
    i_rp_cause = cause;
  endtask

  initial begin
    rst = 1'b1;
    i_iq_vld = 1'b0;
    quiet();

    // Reset behaviour
    tick();
    i_iq_vld = 1'b1;
    #1;
    check("rst_gnt", o_iq_gnt, 0);
    check("rst_rpvld", o_rp_vld, 0);
    tick();
    check("rst_free", o_free_cnt, 8);
    rst = 1'b0;
    #1;
    check("idle_gnt", o_iq_gnt, 1);

    // Miss broadcast: lq 1,2,4 into entries 0,1,2; rr starts at 0
    tick(); i_iq_vld = 1'b0; push(5'd1, 2'd1);
    tick(); push(5'd2, 2'd1); #1; check("miss_free1", o_free_cnt, 7);
    tick(); push(5'd4, 2'd1); #1; check("miss_free2", o_free_cnt, 6);
    tick(); quiet(); i_refill_wake = 1'b1; #1;
    check("miss_waiting", o_rp_vld, 0);
    check("miss_free3", o_free_cnt, 5);
    tick(); quiet(); i_iq_vld = 1'b1; #1;
    check("miss_vld0", o_rp_vld, 1);
    check("miss_lq0", o_rp_lqIdx, 1);
    check("miss_iqdeny", o_iq_gnt, 0);
    tick(); #1;
    check("miss_lq1", o_rp_lqIdx, 2);
    check("miss_free4", o_free_cnt, 6);
    tick(); #1;
    check("miss_lq2", o_rp_lqIdx, 4);
    tick(); #1;
    check("miss_done", o_rp_vld, 0);
    check("miss_free5", o_free_cnt, 8);
    check("miss_gnt", o_iq_gnt, 1);

    // Conflict: injected 3 cycles after push
    tick(); push(5'd3, 2'd0); #1;
    check("cft_push_gnt", o_iq_gnt, 1);
    tick(); quiet(); #1;
    check("cft_c1", o_rp_vld, 0);
    check("cft_free", o_free_cnt, 7);
    tick(); #1;
    check("cft_c2", o_rp_vld, 0);
    tick(); #1;
    check("cft_c3", o_rp_vld, 1);
    check("cft_lq", o_rp_lqIdx, 3);
    check("cft_iqdeny", o_iq_gnt, 0);
    tick(); #1;
    check("cft_gone", o_rp_vld, 0);
    check("cft_free2", o_free_cnt, 8);

    // Push together with matching wake
    tick(); push(5'd9, 2'd3); i_stfwd_wake = 1'b1; #1;
    check("sw_same", o_rp_vld, 0);
    tick(); quiet(); #1;
    check("sw_vld", o_rp_vld, 1);
    check("sw_lq", o_rp_lqIdx, 9);
    // mmio entry must ignore a stfwd wake
    tick(); push(5'd10, 2'd2); i_stfwd_wake = 1'b1; #1;
    check("mm_clear", o_rp_vld, 0);
    tick(); quiet(); i_mmio_wake = 1'b1; #1;
    check("mm_wrongwake", o_rp_vld, 0);
    tick(); quiet(); #1;
    check("mm_vld", o_rp_vld, 1);
    check("mm_lq", o_rp_lqIdx, 10);
    tick(); #1;
    check("mm_gone", o_rp_vld, 0);

    // Capacity guard: six pending misses
    for (int k = 0; k < 6; k++) begin
      tick(); push(5'(20 + k), 2'd1); #1;
      check("cap_free", o_free_cnt, 32'(8 - k));
      check("cap_gnt", o_iq_gnt, 1);
    end
    tick(); quiet(); #1;
    check("cap_free_min", o_free_cnt, 2);
    check("cap_deny", o_iq_gnt, 0);
    check("cap_rpvld", o_rp_vld, 0);

    // Squash with a push and wake in the same cycle
    tick(); i_squash = 1'b1; push(5'd30, 2'd3); i_stfwd_wake = 1'b1; #1;
    check("sq_gnt", o_iq_gnt, 0);
    check("sq_rpvld", o_rp_vld, 0);
    tick(); quiet(); i_refill_wake = 1'b1; #1;
    check("sq_free", o_free_cnt, 8);
    check("sq_rpvld2", o_rp_vld, 0);
    check("sq_gnt2", o_iq_gnt, 1);
    tick(); quiet(); #1;
    check("sq_dropped", o_rp_vld, 0);

    // Continuous replays against a waiting IQ
    tick(); push(5'd1, 2'd3); i_stfwd_wake = 1'b1; #1;
    check("st_first_gnt", o_iq_gnt, 1);
    for (int k = 1; k <= 8; k++) begin
      tick(); push(5'(k + 1), 2'd3); i_stfwd_wake = 1'b1; #1;
      check("st_rpvld", o_rp_vld, 1);
      check("st_lq", o_rp_lqIdx, 32'(k));
      check("st_deny", o_iq_gnt, 0);
    end
    tick(); push(5'd10, 2'd3); i_stfwd_wake = 1'b1; #1;
    check("st9_gnt", o_iq_gnt, 32'(Starve));
    check("st9_rpvld", o_rp_vld, 32'(!Starve));
    tick(); quiet(); #1;
    check("st10_rpvld", o_rp_vld, 1);
    check("st10_lq", o_rp_lqIdx, Starve ? 32'd9 : 32'd10);
    tick(); #1;
    check("st11_rpvld", o_rp_vld, 32'(Starve));
    tick(); #1;
    check("st12_rpvld", o_rp_vld, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
